// File: rtl/nand_pkg.sv
// Shared definitions for the NAND flash interface blocks.
//   - command opcodes driven on the shared command byte
//   - init-sequencer error codes
//   - init-sequencer state encoding (plain constants so older blocks can
//     compare against them directly)
package nand_pkg;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_READID = 8'h90;
  localparam logic [7:0] CMD_STATUS = 8'h70;
  localparam logic [7:0] CMD_NONE   = 8'h00;

  localparam logic [1:0] ERR_NONE   = 2'b00;  // no error
  localparam logic [1:0] ERR_RB     = 2'b01;  // rst_done or R/B# ready timeout
  localparam logic [1:0] ERR_ID_TMO = 2'b10;  // id_done timeout
  localparam logic [1:0] ERR_ID_BAD = 2'b11;  // ID mismatch or short read

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_RST_CMD    = 4'd1;
  localparam logic [3:0] ST_RST_WAIT   = 4'd2;
  localparam logic [3:0] ST_RST_WB     = 4'd3;
  localparam logic [3:0] ST_RST_RDY    = 4'd4;
  localparam logic [3:0] ST_ID_CMD     = 4'd5;
  localparam logic [3:0] ST_ID_COLLECT = 4'd6;
  localparam logic [3:0] ST_CHECK      = 4'd7;
  localparam logic [3:0] ST_PASS       = 4'd8;
  localparam logic [3:0] ST_FAIL       = 4'd9;

  // Sequence is running in every state except the three resting ones.
  function automatic logic st_busy(input logic [3:0] st);
    return !(st == ST_IDLE || st == ST_PASS || st == ST_FAIL);
  endfunction

endpackage

// File: rtl/nand_wait_timer.sv
// Down-counting wait timer used for the per-phase timeouts.
//   clk, reset : clock, asynchronous active-high reset
//   load       : reload counter with load_val (wins over enable)
//   load_val   : value loaded on entry to a waiting phase
//   en         : count down by one per cycle while nonzero
//   expired    : counter has reached zero
module nand_wait_timer #(
  parameter int TIMEOUT_CYCLES = 150000,
  parameter int W              = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/nand_init_seq.sv
// NAND power-up sequencer: RESET (0xFF), wait tWB and R/B# ready, READ ID
// (0x90), capture ID bytes, compare maker/device codes, retry on error.
//   clk, reset : clock, asynchronous active-high reset
//   start      : one-cycle request, accepted only in IDLE/PASS/FAIL
//   nand_rb    : raw R/B# pin (low = busy), synchronized internally
//   rst_done   : RESET command driver finished the 0xFF cycle
//   id_done    : read-ID stage finished
//   id_valid   : one ID byte on id_byte this cycle
//   cmd_data   : command byte to downstream stages, 0 when idle
//   busy       : sequence in progress
//   init_ok    : level, sequence passed
//   init_fail  : level, sequence failed after all attempts
//   err_code   : latest error (see nand_pkg ERR_*)
//   id_word    : captured ID, byte k at [8k+7:8k]
module nand_init_seq #(
  parameter int         TWB_CYCLES     = 15,
  parameter int         TIMEOUT_CYCLES = 150000,
  parameter int         MAX_RETRY      = 3,
  parameter int         ID_BYTES       = 4,
  parameter logic [7:0] EXP_MAKER      = 8'hEC,
  parameter logic [7:0] EXP_DEVICE     = 8'hDA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        nand_rb,
  input  logic        rst_done,
  input  logic        id_done,
  input  logic        id_valid,
  input  logic [7:0]  id_byte,
  output logic [7:0]  cmd_data,
  output logic        busy,
  output logic        init_ok,
  output logic        init_fail,
  output logic [1:0]  err_code,
  output logic [31:0] id_word
);

  import nand_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WW = $clog2(TWB_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  logic          rb_meta, rb_s;
  logic [3:0]    state;
  logic [WW-1:0] wb_cnt;
  logic [RW-1:0] attempt;
  logic [2:0]    idx;
  logic          tmr_load, tmr_en, tmr_expired;
  logic          cap, id_pass, retry_ok;
  logic          err_hit;
  logic [1:0]    err_val;

  // Reload on the cycle before each waiting phase is entered, so the
  // first cycle in the phase already sees the full count.
  assign tmr_load = (state == ST_RST_CMD) ||
                    (state == ST_RST_WB && wb_cnt == '0) ||
                    (state == ST_ID_CMD);
  assign tmr_en   = (state == ST_RST_WAIT) || (state == ST_RST_RDY) ||
                    (state == ST_ID_COLLECT);

  nand_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .W              (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (TW'(TIMEOUT_CYCLES)),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  assign cap      = (state == ST_ID_COLLECT) && id_valid && (idx < 3'(ID_BYTES));
  assign id_pass  = (idx == 3'(ID_BYTES)) && (id_word[7:0] == EXP_MAKER) &&
                    (id_word[15:8] == EXP_DEVICE);
  assign retry_ok = attempt < RW'(MAX_RETRY);

  // Error detection; the awaited event always beats a same-cycle expiry.
  always_comb begin
    err_hit = 1'b0;
    err_val = ERR_NONE;
    case (state)
      ST_RST_WAIT:   if (!rst_done && tmr_expired) begin err_hit = 1'b1; err_val = ERR_RB;     end
      ST_RST_RDY:    if (!rb_s && tmr_expired)     begin err_hit = 1'b1; err_val = ERR_RB;     end
      ST_ID_COLLECT: if (!id_done && tmr_expired)  begin err_hit = 1'b1; err_val = ERR_ID_TMO; end
      ST_CHECK:      if (!id_pass)                 begin err_hit = 1'b1; err_val = ERR_ID_BAD; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_meta   <= 1'b0;
      rb_s      <= 1'b0;
      state     <= ST_IDLE;
      wb_cnt    <= '0;
      attempt   <= '0;
      idx       <= '0;
      cmd_data  <= CMD_NONE;
      busy      <= 1'b0;
      init_ok   <= 1'b0;
      init_fail <= 1'b0;
      err_code  <= ERR_NONE;
      id_word   <= '0;
    end else begin
      rb_meta <= nand_rb;
      rb_s    <= rb_meta;

      // Command byte and busy follow the state one cycle later, so each
      // command lasts exactly the one cycle its state lasts.
      cmd_data <= (state == ST_RST_CMD) ? CMD_RESET :
                  (state == ST_ID_CMD)  ? CMD_READID : CMD_NONE;
      busy     <= st_busy(state);

      // Byte store happens before the id_done transition is acted on, so a
      // last byte arriving with id_done is included in the check.
      if (cap) begin
        for (int k = 0; k < ID_BYTES; k++)
          if (idx == 3'(k)) id_word[8*k +: 8] <= id_byte;
        idx <= idx + 3'd1;
      end

      if (err_hit) begin
        err_code <= err_val;
        if (retry_ok) begin
          attempt <= attempt + RW'(1);
          state   <= ST_RST_CMD;
        end else begin
          init_fail <= 1'b1;
          state     <= ST_FAIL;
        end
      end else begin
        case (state)
          ST_IDLE, ST_PASS, ST_FAIL: begin
            if (start) begin
              state     <= ST_RST_CMD;
              attempt   <= RW'(1);
              id_word   <= '0;
              err_code  <= ERR_NONE;
              init_ok   <= 1'b0;
              init_fail <= 1'b0;
            end
          end
          ST_RST_CMD:  state <= ST_RST_WAIT;
          ST_RST_WAIT: begin
            if (rst_done) begin
              state  <= ST_RST_WB;
              wb_cnt <= WW'(TWB_CYCLES - 1);
            end
          end
          ST_RST_WB: begin
            if (wb_cnt == '0) state <= ST_RST_RDY;
            else              wb_cnt <= wb_cnt - WW'(1);
          end
          ST_RST_RDY:  if (rb_s) state <= ST_ID_CMD;
          ST_ID_CMD: begin
            state   <= ST_ID_COLLECT;
            idx     <= '0;
            id_word <= '0;
          end
          ST_ID_COLLECT: if (id_done) state <= ST_CHECK;
          ST_CHECK: begin
            // only reached on a match; mismatches are taken by err_hit
            state   <= ST_PASS;
            init_ok <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nand_init_seq.sv
// Bench for nand_init_seq: a responder plays the RESET driver, R/B# pin and
// read-ID stage from a per-attempt scenario table; an outcome-level model
// predicts pulses, result, error code and captured ID from the same table.
module tb_nand_init_seq;

  localparam int TWB = 6;
  localparam int TO  = 50;
  localparam int MR  = 3;
  localparam int NB  = 4;
  localparam logic [31:0] NOM = 32'h9510DAEC;

  logic        clk = 1'b0;
  logic        reset, start, nand_rb, rst_done, id_done, id_valid;
  logic [7:0]  id_byte;
  logic [7:0]  cmd_data;
  logic        busy, init_ok, init_fail;
  logic [1:0]  err_code;
  logic [31:0] id_word;

  always #5 clk = ~clk;

  nand_init_seq #(
    .TWB_CYCLES(TWB), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR), .ID_BYTES(NB),
    .EXP_MAKER(8'hEC), .EXP_DEVICE(8'hDA)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .nand_rb(nand_rb),
    .rst_done(rst_done), .id_done(id_done), .id_valid(id_valid),
    .id_byte(id_byte), .cmd_data(cmd_data), .busy(busy), .init_ok(init_ok),
    .init_fail(init_fail), .err_code(err_code), .id_word(id_word)
  );

  int n_chk = 0, n_err = 0;

  // scenario table, one row per attempt (dly<0: rst_done never comes)
  int         cfg_dly [MR];
  bit         cfg_rb  [MR];
  int         cfg_nb  [MR];
  logic [7:0] cfg_b   [MR][6];
  bit         cfg_done[MR];
  bit         cfg_sim [MR];
  int         inject_at = 0, rst_at_rd = 0;

  // observed
  int          ff_cnt, rd_cnt, ff_at, rd_at;
  bit          bad, tmo, busy_at_ff, rst_hit;
  logic        o_ok, o_fail;
  logic [1:0]  o_err;
  logic [31:0] o_word;
  logic [44:0] rst_snap;

  // expected
  logic        m_ok, m_fail;
  logic [1:0]  m_err;
  logic [31:0] m_word;
  int          m_ff, m_rd;

  task automatic set_att(input int a, input int dly, input bit rb, input int nb,
                         input logic [31:0] w, input bit done, input bit sim);
    cfg_dly[a] = dly; cfg_rb[a] = rb; cfg_nb[a] = nb;
    for (int k = 0; k < 4; k++) cfg_b[a][k] = w[8*k +: 8];
    cfg_b[a][4] = 8'($urandom); cfg_b[a][5] = 8'($urandom);
    cfg_done[a] = done; cfg_sim[a] = sim;
  endtask

  // Outcome of a whole run straight from the rules: each attempt is one 0xFF;
  // it reaches 0x90 only if rst_done is in time and R/B# goes ready; the ID
  // attempt passes only with a full, matching ID; stop on pass or after MR.
  function automatic void model();
    m_ok = 0; m_fail = 0; m_err = 0; m_word = 0; m_ff = 0; m_rd = 0;
    for (int a = 0; a < MR && !m_ok; a++) begin
      m_ff++;
      if (cfg_dly[a] < 0 || cfg_dly[a] > TO || !cfg_rb[a]) begin m_err = 2'b01; continue; end
      m_rd++;
      m_word = 0;
      for (int k = 0; k < NB && k < cfg_nb[a]; k++) m_word[8*k +: 8] = cfg_b[a][k];
      if (!cfg_done[a]) m_err = 2'b10;
      else if (cfg_nb[a] >= NB && cfg_b[a][0] == 8'hEC && cfg_b[a][1] == 8'hDA) m_ok = 1;
      else m_err = 2'b11;
    end
    m_fail = !m_ok;
  endfunction

  // Start one run and act as the downstream stages until pass/fail.
  task automatic run_scn();
    int c, t_rst, t_id, a, off, dt;
    logic [7:0] prev;
    ff_cnt = 0; rd_cnt = 0; ff_at = -1; rd_at = -1; bad = 0; tmo = 1; rst_hit = 0;
    a = 0; t_rst = -1; t_id = -1; prev = 8'h00;
    @(negedge clk); start = 1'b1;
    for (c = 1; c <= 3000; c++) begin
      @(negedge clk);
      start = (c == inject_at);
      if (cmd_data != 8'h00 && cmd_data != 8'hFF && cmd_data != 8'h90) bad = 1;
      if (cmd_data != 8'h00 && cmd_data == prev) bad = 1;
      if (init_ok && init_fail) bad = 1;
      if (cmd_data == 8'hFF) begin
        ff_cnt++;
        if (ff_at < 0) begin ff_at = c; busy_at_ff = busy; end
        if (ff_cnt > MR) bad = 1;
        a = (ff_cnt > MR) ? MR - 1 : ff_cnt - 1;
        t_rst = (cfg_dly[a] < 0) ? -1 : c + cfg_dly[a];
        nand_rb = cfg_rb[a];
        t_id = -1;
      end
      if (cmd_data == 8'h90) begin
        rd_cnt++;
        if (rd_at < 0) rd_at = c;
        t_id = c;
        if (rd_cnt == rst_at_rd) begin
          reset = 1'b1; #1;
          rst_snap = {cmd_data, busy, init_ok, init_fail, err_code, id_word};
          rst_hit = 1;
        end
      end
      prev = cmd_data;
      rst_done = (c == t_rst);
      id_valid = 0; id_byte = 8'h00; id_done = 0;
      if (t_id >= 0) begin
        off = c - t_id;
        if (off >= 2 && off % 2 == 0 && (off - 2) / 2 < cfg_nb[a]) begin
          id_valid = 1; id_byte = cfg_b[a][(off - 2) / 2];
        end
        dt = cfg_sim[a] ? t_id + 2 * cfg_nb[a] : t_id + 2 + 2 * cfg_nb[a];
        if (cfg_done[a] && c == dt) id_done = 1;
      end
      if (rst_hit || init_ok || init_fail) begin tmo = 0; break; end
    end
    start = 0; rst_done = 0; id_valid = 0; id_done = 0; id_byte = 8'h00;
    o_ok = init_ok; o_fail = init_fail; o_err = err_code; o_word = id_word;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; nand_rb = 0; rst_done = 0; id_done = 0; id_valid = 0; id_byte = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({cmd_data, busy, init_ok, init_fail, err_code, id_word} !== 45'd0) begin
      n_err++; $display("FAIL reset_held outs got %h want 0", {cmd_data, busy, init_ok, init_fail, err_code, id_word});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({cmd_data, busy, init_ok, init_fail, err_code, id_word} !== 45'd0) begin
      n_err++; $display("FAIL reset_idle outs got %h want 0", {cmd_data, busy, init_ok, init_fail, err_code, id_word});
    end
  endtask

  task automatic test_nominal();
    for (int a = 0; a < MR; a++) set_att(a, 3, 1, 4, NOM, 1, 0);
    inject_at = 5;  // start while busy must be ignored
    run_scn();
    inject_at = 0;
    n_chk++;
    if ({o_ok, o_fail, o_err, o_word} !== {1'b1, 1'b0, 2'b00, NOM}) begin
      n_err++; $display("FAIL nominal ok/fail/err/word got %b/%b/%0d/%h want 1/0/0/%h", o_ok, o_fail, o_err, o_word, NOM);
    end
    n_chk++;
    if (ff_cnt != 1 || rd_cnt != 1) begin
      n_err++; $display("FAIL nominal_pulses ff/rd got %0d/%0d want 1/1", ff_cnt, rd_cnt);
    end
    n_chk++;
    if (busy_at_ff !== 1'b1) begin
      n_err++; $display("FAIL nominal_busy got %b want 1", busy_at_ff);
    end
    n_chk++;
    if ({tmo, bad} !== 2'b00) begin
      n_err++; $display("FAIL nominal_proto tmo/bad got %b/%b want 0/0", tmo, bad);
    end
  endtask

  task automatic test_latency();
    nand_rb = 1'b1;
    repeat (3) @(negedge clk);
    for (int a = 0; a < MR; a++) set_att(a, 0, 1, 4, NOM, 1, 0);
    run_scn();
    n_chk++;
    if (ff_at != 2 || rd_at != TWB + 5) begin
      n_err++; $display("FAIL latency ff_at/rd_at got %0d/%0d want 2/%0d", ff_at, rd_at, TWB + 5);
    end
    n_chk++;
    if (o_ok !== 1'b1 || bad || tmo) begin
      n_err++; $display("FAIL latency_result ok/bad/tmo got %b/%b/%b want 1/0/0", o_ok, bad, tmo);
    end
  endtask

  task automatic test_rb_stuck();
    for (int a = 0; a < MR; a++) set_att(a, 2, 0, 4, NOM, 1, 0);
    model(); run_scn();
    n_chk++;
    if ({o_ok, o_fail, o_err} !== {1'b0, 1'b1, 2'b01} || ff_cnt != 3 || rd_cnt != 0) begin
      n_err++; $display("FAIL rb_stuck ok/fail/err/ff/rd got %b/%b/%0d/%0d/%0d want 0/1/1/3/0", o_ok, o_fail, o_err, ff_cnt, rd_cnt);
    end
    n_chk++;
    if ({o_ok, o_fail, o_err, o_word} !== {m_ok, m_fail, m_err, m_word} || tmo || bad) begin
      n_err++; $display("FAIL rb_stuck_model got %b/%b/%0d/%h want %b/%b/%0d/%h", o_ok, o_fail, o_err, o_word, m_ok, m_fail, m_err, m_word);
    end
  endtask

  task automatic test_wrong_maker();
    set_att(0, 1, 1, 4, 32'h9510DA2C, 1, 0);
    set_att(1, 4, 1, 4, 32'h9510DA2C, 1, 0);
    set_att(2, 2, 1, 4, NOM, 1, 0);
    run_scn();
    n_chk++;
    if ({o_ok, o_fail, o_err, o_word} !== {1'b1, 1'b0, 2'b11, NOM} || ff_cnt != 3 || rd_cnt != 3) begin
      n_err++; $display("FAIL wrong_maker ok/fail/err/word/ff/rd got %b/%b/%0d/%h/%0d/%0d want 1/0/3/%h/3/3", o_ok, o_fail, o_err, o_word, ff_cnt, rd_cnt, NOM);
    end
  endtask

  task automatic test_short_simul();
    for (int a = 0; a < MR; a++) set_att(a, 1, 1, 2, NOM, 1, 0);
    run_scn();
    n_chk++;
    if ({o_ok, o_fail, o_err, o_word} !== {1'b0, 1'b1, 2'b11, 32'h0000DAEC}) begin
      n_err++; $display("FAIL short_id ok/fail/err/word got %b/%b/%0d/%h want 0/1/3/0000daec", o_ok, o_fail, o_err, o_word);
    end
    for (int a = 0; a < MR; a++) set_att(a, 1, 1, 4, NOM, 1, 1);
    run_scn();
    n_chk++;
    if ({o_ok, o_fail, o_err, o_word} !== {1'b1, 1'b0, 2'b00, NOM} || rd_cnt != 1) begin
      n_err++; $display("FAIL simul_last ok/fail/err/word/rd got %b/%b/%0d/%h/%0d want 1/0/0/%h/1", o_ok, o_fail, o_err, o_word, rd_cnt, NOM);
    end
  endtask

  task automatic test_no_done();
    for (int a = 0; a < MR; a++) set_att(a, 2, 1, 6, NOM, 0, 0);
    run_scn();
    n_chk++;
    if ({o_ok, o_fail, o_err, o_word} !== {1'b0, 1'b1, 2'b10, NOM} || rd_cnt != 3 || tmo) begin
      n_err++; $display("FAIL no_done ok/fail/err/word/rd got %b/%b/%0d/%h/%0d want 0/1/2/%h/3", o_ok, o_fail, o_err, o_word, rd_cnt, NOM);
    end
  endtask

  task automatic test_tmo_edge();
    set_att(0, TO + 1, 1, 4, NOM, 1, 0);
    set_att(1, TO, 1, 4, NOM, 1, 0);
    set_att(2, 0, 1, 4, NOM, 1, 0);
    run_scn();
    n_chk++;
    if ({o_ok, o_err} !== {1'b1, 2'b01} || ff_cnt != 2 || rd_cnt != 1) begin
      n_err++; $display("FAIL tmo_edge ok/err/ff/rd got %b/%0d/%0d/%0d want 1/1/2/1", o_ok, o_err, ff_cnt, rd_cnt);
    end
  endtask

  task automatic test_reset_mid();
    set_att(0, 1, 1, 4, 32'h9510DA2C, 1, 0);
    for (int a = 1; a < MR; a++) set_att(a, 1, 1, 4, NOM, 1, 0);
    rst_at_rd = 2;
    run_scn();
    rst_at_rd = 0;
    n_chk++;
    if (!rst_hit || rst_snap !== 45'd0) begin
      n_err++; $display("FAIL reset_mid hit/outs got %b/%h want 1/0", rst_hit, rst_snap);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    for (int a = 0; a < MR; a++) set_att(a, 3, 1, 4, NOM, 1, 0);
    run_scn();
    n_chk++;
    if ({o_ok, o_fail, o_err, o_word} !== {1'b1, 1'b0, 2'b00, NOM} || ff_cnt != 1 || bad || tmo) begin
      n_err++; $display("FAIL after_reset ok/fail/err/word/ff got %b/%b/%0d/%h/%0d want 1/0/0/%h/1", o_ok, o_fail, o_err, o_word, ff_cnt, NOM);
    end
  endtask

  task automatic test_random();
    int r, dly, nb;
    logic [31:0] w;
    for (int i = 0; i < 30; i++) begin
      for (int a = 0; a < MR; a++) begin
        r = $urandom_range(0, 9);
        dly = (r == 0) ? -1 : (r == 1) ? TO : (r == 2) ? TO + 1 : $urandom_range(0, 8);
        nb = $urandom_range(0, 6);
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[7:0] = 8'hEC;
        if ($urandom_range(0, 3) != 0) w[15:8] = 8'hDA;
        set_att(a, dly, $urandom_range(0, 7) != 0, nb, w,
                $urandom_range(0, 4) != 0, nb > 0 && $urandom_range(0, 1) == 1);
      end
      model(); run_scn();
      n_chk++;
      if ({o_ok, o_fail, o_err, o_word} !== {m_ok, m_fail, m_err, m_word}) begin
        n_err++; $display("FAIL random[%0d] ok/fail/err/word got %b/%b/%0d/%h want %b/%b/%0d/%h", i, o_ok, o_fail, o_err, o_word, m_ok, m_fail, m_err, m_word);
      end
      n_chk++;
      if (ff_cnt != m_ff || rd_cnt != m_rd || bad || tmo) begin
        n_err++; $display("FAIL random_pulses[%0d] ff/rd/bad/tmo got %0d/%0d/%b/%b want %0d/%0d/0/0", i, ff_cnt, rd_cnt, bad, tmo, m_ff, m_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_latency();
    test_rb_stuck();
    test_wrong_maker();
    test_short_simul();
    test_no_done();
    test_tmo_edge();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
